// File: rtl/clkwiz_reconfig_sequencer_if.sv
// AXI4-Lite write-channel bundle between the reconfig sequencer (master) and the clk_wiz slave.
// Valid/ready: a beat transfers on a rising edge where valid and ready are both high; valid is held until then.
interface clkwiz_reconfig_sequencer_if #(
  parameter int ADDR_W = 11
) ();
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [31:0]       s_axi_wdata;
  logic [3:0]        s_axi_wstrb;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready;

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid
  );
endinterface

// File: rtl/clkwiz_reconfig_sequencer.sv
// Writes cfg0, cfg1 and the load command to clk_wiz over AXI4-Lite, then supervises unlock/relock.
// A one-deep pending slot holds the newest request that arrives while a sequence is running.
module clkwiz_reconfig_sequencer #(
  parameter int                ADDR_W       = 11,
  parameter logic [ADDR_W-1:0] ADDR_CFG0    = 11'h200,
  parameter logic [ADDR_W-1:0] ADDR_CFG1    = 11'h208,
  parameter logic [ADDR_W-1:0] ADDR_LOAD    = 11'h25C,
  parameter logic [31:0]       LOAD_VALUE   = 32'h00000003,
  parameter int                LOCK_TIMEOUT = 65535
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        NewDataReady_in,
  input  logic [31:0] cfg0_in,
  input  logic [31:0] cfg1_in,
  input  logic        locked_in,
  clkwiz_reconfig_sequencer_if.master axi,
  output logic        busy_out,
  output logic        done_out,
  output logic [1:0]  err_out,
  output logic [2:0]  stateDbg
);
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ISSUE       = 3'd1,
    WAIT_B      = 3'd2,
    WAIT_UNLOCK = 3'd3,
    WAIT_LOCK   = 3'd4,
    DONE        = 3'd5
  } state_t;

  state_t            stateQ, stateD;
  logic [1:0]        idxQ, idxD;
  logic [31:0]       cfg0Q, cfg0D, cfg1Q, cfg1D;
  logic [31:0]       pend0Q, pend0D, pend1Q, pend1D;
  logic              pendingQ, pendingD;
  logic [1:0]        errQ, errD;
  logic [CNT_W-1:0]  cntQ, cntD;
  logic              awvalidQ, awvalidD, wvalidQ, wvalidD;
  logic              awDoneQ, awDoneD, wDoneQ, wDoneD;
  logic [ADDR_W-1:0] awaddrQ, awaddrD;
  logic [31:0]       wdataQ, wdataD;

  logic              awHs, wHs, timeoutHit;
  logic [CNT_W-1:0]  cntInc;

  assign awHs       = awvalidQ & axi.s_axi_awready;
  assign wHs        = wvalidQ & axi.s_axi_wready;
  // Fires on the cycle whose increment lands on LOCK_TIMEOUT, so each wait state lasts at most LOCK_TIMEOUT cycles.
  assign timeoutHit = (cntQ == CNT_W'(LOCK_TIMEOUT - 1));
  assign cntInc     = (cntQ == CNT_W'(LOCK_TIMEOUT)) ? cntQ : cntQ + CNT_W'(1);

  always_comb begin
    stateD   = stateQ;
    idxD     = idxQ;
    cfg0D    = cfg0Q;
    cfg1D    = cfg1Q;
    pend0D   = pend0Q;
    pend1D   = pend1Q;
    pendingD = pendingQ;
    errD     = errQ;
    cntD     = cntQ;
    awvalidD = awvalidQ;
    wvalidD  = wvalidQ;
    awDoneD  = awDoneQ;
    wDoneD   = wDoneQ;
    awaddrD  = awaddrQ;
    wdataD   = wdataQ;

    if (NewDataReady_in && stateQ != IDLE) begin
      pend0D   = cfg0_in;
      pend1D   = cfg1_in;
      pendingD = 1'b1;
    end

    case (stateQ)
      IDLE: begin
        if (NewDataReady_in) begin
          cfg0D    = cfg0_in;
          cfg1D    = cfg1_in;
          idxD     = 2'd0;
          errD     = 2'b00;
          pendingD = 1'b0;
          stateD   = ISSUE;
        end else if (pendingQ) begin
          cfg0D    = pend0Q;
          cfg1D    = pend1Q;
          idxD     = 2'd0;
          errD     = 2'b00;
          pendingD = 1'b0;
          stateD   = ISSUE;
        end
      end
      ISSUE: begin
        if (awHs) begin
          awvalidD = 1'b0;
          awDoneD  = 1'b1;
        end
        if (wHs) begin
          wvalidD = 1'b0;
          wDoneD  = 1'b1;
        end
        if ((awDoneQ | awHs) && (wDoneQ | wHs)) stateD = WAIT_B;
      end
      WAIT_B: begin
        if (axi.s_axi_bvalid) begin
          if (axi.s_axi_bresp != 2'b00) begin
            errD   = 2'b01;
            stateD = DONE;
          end else if (idxQ < 2'd2) begin
            idxD   = idxQ + 2'd1;
            stateD = ISSUE;
          end else begin
            cntD   = '0;
            stateD = WAIT_UNLOCK;
          end
        end
      end
      WAIT_UNLOCK: begin
        cntD = cntInc;
        if (!locked_in) begin
          cntD   = '0;
          stateD = WAIT_LOCK;
        end else if (timeoutHit) begin
          errD   = 2'b10;
          stateD = DONE;
        end
      end
      WAIT_LOCK: begin
        cntD = cntInc;
        if (locked_in) begin
          errD   = 2'b00;
          stateD = DONE;
        end else if (timeoutHit) begin
          errD   = 2'b10;
          stateD = DONE;
        end
      end
      DONE:    stateD = IDLE;
      default: stateD = IDLE;
    endcase

    // Payload is loaded on the edge that enters ISSUE so it is valid in the first ISSUE cycle.
    if (stateD == ISSUE && stateQ != ISSUE) begin
      awvalidD = 1'b1;
      wvalidD  = 1'b1;
      awDoneD  = 1'b0;
      wDoneD   = 1'b0;
      case (idxD)
        2'd0: begin
          awaddrD = ADDR_CFG0;
          wdataD  = cfg0D;
        end
        2'd1: begin
          awaddrD = ADDR_CFG1;
          wdataD  = cfg1D;
        end
        default: begin
          awaddrD = ADDR_LOAD;
          wdataD  = LOAD_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      stateQ   <= IDLE;
      idxQ     <= 2'd0;
      cfg0Q    <= '0;
      cfg1Q    <= '0;
      pend0Q   <= '0;
      pend1Q   <= '0;
      pendingQ <= 1'b0;
      errQ     <= 2'b00;
      cntQ     <= '0;
      awvalidQ <= 1'b0;
      wvalidQ  <= 1'b0;
      awDoneQ  <= 1'b0;
      wDoneQ   <= 1'b0;
      awaddrQ  <= '0;
      wdataQ   <= '0;
    end else begin
      stateQ   <= stateD;
      idxQ     <= idxD;
      cfg0Q    <= cfg0D;
      cfg1Q    <= cfg1D;
      pend0Q   <= pend0D;
      pend1Q   <= pend1D;
      pendingQ <= pendingD;
      errQ     <= errD;
      cntQ     <= cntD;
      awvalidQ <= awvalidD;
      wvalidQ  <= wvalidD;
      awDoneQ  <= awDoneD;
      wDoneQ   <= wDoneD;
      awaddrQ  <= awaddrD;
      wdataQ   <= wdataD;
    end
  end

  assign axi.s_axi_awaddr  = awaddrQ;
  assign axi.s_axi_awvalid = awvalidQ;
  assign axi.s_axi_wdata   = wdataQ;
  assign axi.s_axi_wstrb   = 4'hF;
  assign axi.s_axi_wvalid  = wvalidQ;
  assign axi.s_axi_bready  = (stateQ == WAIT_B);

  assign busy_out = (stateQ != IDLE);
  assign done_out = (stateQ == DONE);
  assign err_out  = errQ;
  assign stateDbg = stateQ;
endmodule

// File: tb/tb_clkwiz_reconfig_sequencer.sv
// Directed bench: an AXI slave/lock model feeds a scoreboard of expected {addr,data} writes.
module tb_clkwiz_reconfig_sequencer;
  logic        sysclk;
  logic        reset;
  logic        newDataReady;
  logic [31:0] cfg0, cfg1;
  logic        locked;
  logic        busy, done;
  logic [1:0]  err;
  logic [2:0]  stateDbg;

  clkwiz_reconfig_sequencer_if #(.ADDR_W(11)) axi ();

  clkwiz_reconfig_sequencer #(.LOCK_TIMEOUT(16)) dut (
    .sysclk          (sysclk),
    .reset           (reset),
    .NewDataReady_in (newDataReady),
    .cfg0_in         (cfg0),
    .cfg1_in         (cfg1),
    .locked_in       (locked),
    .axi             (axi),
    .busy_out        (busy),
    .done_out        (done),
    .err_out         (err),
    .stateDbg        (stateDbg)
  );

  // clock / reset
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int errors = 0;
  int checks = 0;
  logic [42:0] exp_q[$];

  int          awDelay = 0, wDelay = 0, lockMode = 0;
  logic [10:0] errAddr = 11'h7FF;
  int          awHsCount = 0, wHsCount = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // AXI slave + lock model, all activity on the falling edge
  initial begin : slave
    int cyc, awWait, wWait, lockFallAt, lockRiseAt;
    logic awFirePrev, wFirePrev, bFirePrev, haveA, haveW;
    logic [10:0] awaddrPrev, capA;
    logic [31:0] wdataPrev, capW;
    logic [3:0]  wstrbPrev;
    logic [42:0] expWr;
    cyc = 0; awWait = 0; wWait = 0; lockFallAt = -1; lockRiseAt = -1;
    awFirePrev = 0; wFirePrev = 0; bFirePrev = 0; haveA = 0; haveW = 0;
    awaddrPrev = '0; capA = '0; wdataPrev = '0; capW = '0; wstrbPrev = '0;
    axi.s_axi_awready = 0; axi.s_axi_wready = 0; axi.s_axi_bvalid = 0; axi.s_axi_bresp = 2'b00;
    locked = 1'b1;
    forever begin
      @(negedge sysclk);
      cyc++;
      if (!reset) begin
        awWait = 0; wWait = 0; lockFallAt = -1; lockRiseAt = -1;
        awFirePrev = 0; wFirePrev = 0; bFirePrev = 0; haveA = 0; haveW = 0;
        axi.s_axi_awready = 0; axi.s_axi_wready = 0; axi.s_axi_bvalid = 0; axi.s_axi_bresp = 2'b00;
        locked = 1'b1;
      end else begin
        if (awFirePrev) begin
          awHsCount++;
          check("awvalid_drop", axi.s_axi_awvalid, 1'b0);
          axi.s_axi_awready = 0; awWait = 0; capA = awaddrPrev; haveA = 1;
        end
        if (wFirePrev) begin
          wHsCount++;
          check("wvalid_drop", axi.s_axi_wvalid, 1'b0);
          check("wstrb", wstrbPrev, 4'hF);
          axi.s_axi_wready = 0; wWait = 0; capW = wdataPrev; haveW = 1;
        end
        if (bFirePrev) axi.s_axi_bvalid = 0;
        if (haveA && haveW) begin
          haveA = 0; haveW = 0;
          check("write_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            expWr = exp_q.pop_front();
            check("write_addr_data", {capA, capW}, expWr);
          end
          axi.s_axi_bresp  = (capA == errAddr) ? 2'b10 : 2'b00;
          axi.s_axi_bvalid = 1;
          if (capA == 11'h25C) begin
            lockFallAt = cyc + 4;
            lockRiseAt = cyc + 19;
          end
        end
        if (axi.s_axi_awvalid && !axi.s_axi_awready) begin
          if (awWait >= awDelay) axi.s_axi_awready = 1; else awWait++;
        end
        if (axi.s_axi_wvalid && !axi.s_axi_wready) begin
          if (wWait >= wDelay) axi.s_axi_wready = 1; else wWait++;
        end
        if (lockMode == 0) begin
          if (cyc == lockFallAt) locked = 1'b0;
          if (cyc == lockRiseAt) locked = 1'b1;
        end
        awFirePrev = axi.s_axi_awvalid && axi.s_axi_awready;
        awaddrPrev = axi.s_axi_awaddr;
        wFirePrev  = axi.s_axi_wvalid && axi.s_axi_wready;
        wdataPrev  = axi.s_axi_wdata;
        wstrbPrev  = axi.s_axi_wstrb;
        bFirePrev  = axi.s_axi_bvalid && axi.s_axi_bready;
      end
    end
  end

  // driver tasks
  task automatic push_seq(input logic [31:0] c0, input logic [31:0] c1, input int n);
    if (n >= 1) exp_q.push_back({11'h200, c0});
    if (n >= 2) exp_q.push_back({11'h208, c1});
    if (n >= 3) exp_q.push_back({11'h25C, 32'h00000003});
  endtask

  task automatic strobe(input logic [31:0] c0, input logic [31:0] c1);
    @(negedge sysclk);
    newDataReady = 1'b1; cfg0 = c0; cfg1 = c1;
    @(negedge sysclk);
    newDataReady = 1'b0;
  endtask

  task automatic wait_done(input int budget, input logic [1:0] expErr, input string tag);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge sysclk);
      n++;
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_err"}, err, expErr);
    @(negedge sysclk);
    check({tag, "_pulse"}, done, 1'b0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_awvalid"}, axi.s_axi_awvalid, 1'b0);
    check({tag, "_wvalid"}, axi.s_axi_wvalid, 1'b0);
    check({tag, "_bready"}, axi.s_axi_bready, 1'b0);
    check({tag, "_awaddr"}, axi.s_axi_awaddr, 11'h000);
    check({tag, "_wdata"}, axi.s_axi_wdata, 32'h0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 2'b00);
    check({tag, "_state"}, stateDbg, 3'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: observed=no finish expected=finish within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n, aw0, w0;
    reset = 1'b0; newDataReady = 1'b0; cfg0 = '0; cfg1 = '0;
    repeat (3) @(negedge sysclk);
    check_reset("por");
    reset = 1'b1;
    repeat (2) @(negedge sysclk);

    // 1: nominal sequence
    push_seq(32'h0000_0A01, 32'h0000_0004, 3);
    strobe(32'h0000_0A01, 32'h0000_0004);
    wait_done(300, 2'b00, "s1");
    check("s1_busy_after", busy, 1'b0);
    check("s1_queue_empty", exp_q.size(), 0);

    // 2: wready leads awready by 3 cycles
    awDelay = 3; wDelay = 0;
    aw0 = awHsCount; w0 = wHsCount;
    push_seq(32'h0000_0A01, 32'h0000_0004, 3);
    strobe(32'h0000_0A01, 32'h0000_0004);
    wait_done(300, 2'b00, "s2");
    check("s2_aw_handshakes", awHsCount - aw0, 3);
    check("s2_w_handshakes", wHsCount - w0, 3);
    check("s2_queue_empty", exp_q.size(), 0);
    awDelay = 0;

    // 3: error response on the CFG1 write
    errAddr = 11'h208;
    aw0 = awHsCount;
    push_seq(32'h0000_0C05, 32'h0000_0008, 2);
    strobe(32'h0000_0C05, 32'h0000_0008);
    wait_done(300, 2'b01, "s3");
    repeat (5) @(negedge sysclk);
    check("s3_aw_handshakes", awHsCount - aw0, 2);
    check("s3_queue_empty", exp_q.size(), 0);
    check("s3_idle", stateDbg, 3'd0);
    check("s3_err_held", err, 2'b01);
    errAddr = 11'h7FF;

    // 4: lock never drops, timeout after 16 cycles in WAIT_UNLOCK
    lockMode = 1;
    push_seq(32'h0000_0B02, 32'h0000_0003, 3);
    strobe(32'h0000_0B02, 32'h0000_0003);
    check("s4_err_cleared", err, 2'b00);
    n = 0;
    while (stateDbg !== 3'd3 && n < 200) begin
      @(negedge sysclk);
      n++;
    end
    check("s4_enter_unlock", stateDbg, 3'd3);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge sysclk);
      n++;
    end
    check("s4_timeout_cycles", n, 16);
    check("s4_err", err, 2'b10);
    @(negedge sysclk);
    check("s4_pulse", done, 1'b0);
    check("s4_busy_after", busy, 1'b0);
    lockMode = 0;

    // 5: two strobes while busy, newest pending wins
    push_seq(32'h0000_0333, 32'h0000_0005, 3);
    push_seq(32'h0000_0222, 32'h0000_0007, 3);
    strobe(32'h0000_0333, 32'h0000_0005);
    repeat (3) @(negedge sysclk);
    strobe(32'h0000_0111, 32'h0000_0006);
    strobe(32'h0000_0222, 32'h0000_0007);
    wait_done(300, 2'b00, "s5a");
    wait_done(300, 2'b00, "s5b");
    repeat (10) @(negedge sysclk);
    check("s5_busy_after", busy, 1'b0);
    check("s5_queue_empty", exp_q.size(), 0);

    // 6: reset while awvalid is high in ISSUE
    awDelay = 10; wDelay = 10;
    push_seq(32'h0000_0ABC, 32'h0000_0009, 3);
    strobe(32'h0000_0ABC, 32'h0000_0009);
    check("s6_awvalid_before", axi.s_axi_awvalid, 1'b1);
    #1 reset = 1'b0;
    #1 check_reset("s6_rst");
    exp_q.delete();
    repeat (2) @(negedge sysclk);
    reset = 1'b1;
    awDelay = 0; wDelay = 0;
    repeat (2) @(negedge sysclk);
    push_seq(32'h0000_0B0C, 32'h0000_0002, 3);
    strobe(32'h0000_0B0C, 32'h0000_0002);
    wait_done(300, 2'b00, "s6b");
    check("s6_busy_after", busy, 1'b0);
    check("s6_queue_empty", exp_q.size(), 0);

    // report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/clkwiz_reconfig_sequencer.md
Name: clkwiz_reconfig_sequencer

Overview:
Sequences dynamic reconfiguration of the clocking-wizard core over its AXI4-Lite write channel. A request carries a feedback/multiply word and an output-divide word. The block writes both, then writes the load command, then supervises the lock unlock/relock cycle and reports completion or error. It sits between the frequency-request source and the clk_wiz AXI slave, and runs in the AXI clock domain.

Parameters:
ADDR_W, 11, AXI address width
ADDR_CFG0, 11'h200, address of the multiply/divclk register
ADDR_CFG1, 11'h208, address of the CLKOUT0 divide register
ADDR_LOAD, 11'h25C, address of the load/SEN register
LOAD_VALUE, 32'h00000003, data written to ADDR_LOAD
LOCK_TIMEOUT, 65535, maximum cycles spent in each lock-wait state

Ports:
sysclk  in  1  AXI clock; all logic is on the rising edge
reset  in  1  asynchronous, active-low reset
NewDataReady_in  in  1  one-cycle request strobe
cfg0_in  in  32  word written to ADDR_CFG0
cfg1_in  in  32  word written to ADDR_CFG1
locked_in  in  1  clk_wiz locked, already synchronised to sysclk
s_axi_awaddr  out  ADDR_W  write address
s_axi_awvalid  out  1  address valid
s_axi_awready  in  1  address accepted
s_axi_wdata  out  32  write data
s_axi_wstrb  out  4  always 4'hF
s_axi_wvalid  out  1  data valid
s_axi_wready  in  1  data accepted
s_axi_bresp  in  2  write response
s_axi_bvalid  in  1  response valid
s_axi_bready  out  1  response ready
busy_out  out  1  high whenever state != IDLE
done_out  out  1  one-cycle completion pulse
err_out  out  2  00 ok, 01 bad bresp, 10 lock timeout; held until next start

Behaviour:
- Reset (reset=0, async): state=IDLE; idx=0; all valid/ready outputs 0; awaddr=0; wdata=0; busy_out=0; done_out=0; err_out=00; pending=0. A reset mid-transaction drops awvalid/wvalid immediately. The clk_wiz shares this reset domain.
- States: IDLE, ISSUE, WAIT_B, WAIT_UNLOCK, WAIT_LOCK, DONE.
- IDLE:
  - If NewDataReady_in=1, latch cfg0_in/cfg1_in into the active registers, set idx=0, clear err_out, and go to ISSUE next cycle.
  - Else, if pending=1, load the pending registers, clear pending, and go to ISSUE.
- ISSUE:
  - The address/data pair is selected by idx: 0 -> (ADDR_CFG0, cfg0), 1 -> (ADDR_CFG1, cfg1), 2 -> (ADDR_LOAD, LOAD_VALUE).
  - awvalid and wvalid are asserted in the first ISSUE cycle.
  - Each valid drops the cycle after its own ready handshake; the two handshakes are independent and may occur in either order or together.
  - awaddr and wdata are stable while their valid is high.
  - When both handshakes have completed, go to WAIT_B.
- WAIT_B: bready=1. On bvalid:
  - bresp != 00: err_out=01, go to DONE (remaining writes are skipped).
  - bresp == 00 and idx<2: idx++, return to ISSUE.
  - bresp == 00 and idx==2: clear the timeout counter, go to WAIT_UNLOCK.
- WAIT_UNLOCK:
  - locked_in=0: clear the counter, go to WAIT_LOCK.
  - Counter reaches LOCK_TIMEOUT: err_out=10, go to DONE.
- WAIT_LOCK:
  - locked_in=1: go to DONE with err_out=00.
  - Counter reaches LOCK_TIMEOUT: err_out=10, go to DONE.
- Timeout counter: width $clog2(LOCK_TIMEOUT+1); increments once per cycle in the wait states; saturates, never wraps.
- DONE: done_out=1 for exactly this cycle, then IDLE. Minimum latency from a strobe to done_out with zero-wait AXI, bvalid one cycle after the handshake, and an immediate unlock/relock is 3×(ISSUE+WAIT_B) + 2 + 1 cycles.
- Pending slot (one deep):
  - A NewDataReady_in while state != IDLE (including DONE) writes cfg0/cfg1 into the pending registers and sets pending.
  - A later strobe overwrites the pending slot (newest wins); the in-flight sequence is never disturbed.
  - A strobe arriving in IDLE in the same cycle as pending=1 starts the new data and clears pending; the stale data is discarded.
- busy_out is registered: it rises the cycle after the accepted strobe and falls on entry to IDLE.

Test Plan:
1. cfg0=32'h0000_0A01, cfg1=32'h0000_0004, zero-wait slave, bresp=00, locked falls 5 cycles and rises 20 cycles after the load write. Expect three writes in order: 0x200/0A01, 0x208/0004, 0x25C/0003. Expect one done_out pulse, err_out=00, and busy_out low afterwards.
2. Slave asserts wready 3 cycles before awready on every write. Expect each valid to drop independently, no duplicate handshake, and the same three writes as scenario 1.
3. bresp=10 on the 0x208 write. Expect no 0x25C write, err_out=01, one done_out pulse, and return to IDLE.
4. locked_in stuck at 1 with LOCK_TIMEOUT=16. Expect done_out exactly 16 cycles after entry to WAIT_UNLOCK, with err_out=10.
5. Two strobes during busy (cfg0 = 0x111 then 0x222). Expect the first sequence to complete untouched, then exactly one further sequence writing 0x222 to 0x200.
6. Assert reset low while awvalid=1 in ISSUE. Expect all outputs at reset values immediately. After release, a new strobe runs a clean 3-write sequence.
